os_encoder: RTL and testbench
=============================

Name: os_encoder

Overview:
- Transmit-side counterpart of the ordered-set decoder.
- Accepts one complete, lane-major ordered set (16 symbols per lane, up to 16 lanes) from the LTSSM/OS generator.
- Serialises it into byte-interleaved multi-lane beats of the current PIPE width for the lane management (LMC) block.
- Back-to-back ordered sets are sent without bubbles, and LMC backpressure is honoured.

Parameters:
- GEN1_PIPEWIDTH, 64, bits per lane per beat at gen1
- GEN2_PIPEWIDTH, 8, bits per lane per beat at gen2
- GEN3_PIPEWIDTH, 8, bits per lane per beat at gen3
- GEN4_PIPEWIDTH, 8, bits per lane per beat at gen4
- GEN5_PIPEWIDTH, 8, bits per lane per beat at gen5

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- gen  input  3  link generation, 1..5
- numberOfDetectedLanes  input  5  active lane count N: 1, 2, 4, 8 or 16
- osIn  input  2048  ordered set; lane L symbol k at osIn[128*L+8*k +: 8]
- osValid  input  1  osIn valid
- osReady  output  1  encoder can accept osIn this cycle
- lmcReady  input  1  LMC accepts the current beat
- dataOut  output  512  beat to LMC; earliest byte in bits [7:0]
- validToLMC  output  1  dataOut valid

Behaviour:
- Reset (synchronous, active-high), takes effect the cycle after reset is sampled high:
  - state=IDLE, osReady=1, validToLMC=0, dataOut=0, byteIdx=0.
  - Internal registers are cleared.
  - An ordered set in flight is discarded; no partial completion.
- Shift value S from N: 1→0, 2→1, 4→2, 8→3, 16→4.
- Any other N is illegal:
  - osReady=0, nothing is accepted.
  - An ordered set already in SEND completes using its captured N.
- Beat width W = GENx_PIPEWIDTH<<S, with GENx selected by gen; W saturates at 512.
- Bytes per beat B = W/8. Total bytes T = 16*N.
- Illegal gen (0, 6, 7) is treated like illegal N: osReady=0.
- Byte mapping: stream byte j carries lane (j mod N), symbol (j div N), i.e. osIn[128*(j mod N) + 8*(j div N) +: 8]. This is the inverse of the decoder's lane de-interleave.
- Beat at byteIdx: dataOut[8*m +: 8] = stream byte (byteIdx+m) for m<B; bits at and above W are 0.
- FSM, two states:
  - IDLE:
    - osReady=1 when gen and N are legal.
    - On osValid&&osReady: capture osIn, N, B, T into registers; byteIdx=0; go to SEND.
    - gen/N changes after capture are ignored until the next accept.
  - SEND:
    - validToLMC=1; dataOut is driven combinationally from the captured registers and byteIdx.
    - On lmcReady: byteIdx+=B. The last beat is byteIdx+B>=T.
    - On the last beat with lmcReady: if osValid and gen/N are legal, capture the new ordered set, set byteIdx=0 and stay in SEND; otherwise go to IDLE.
- osReady in SEND = lastBeat && lmcReady && legal. This is the only overlap point.
- Latency: the first beat is visible the cycle after acceptance.
- Stall: while lmcReady=0, dataOut, validToLMC and byteIdx hold stable.
- Symbols are passed verbatim for all gens. No scrambling, no sync header, no 8b/10b; these belong to downstream blocks.
- Byte counters are 9 bits wide; no wrap is possible because T≤256.

Test Plan:
- gen=1, N=2, lane0 symbols 0x00..0x0F, lane1 0x10..0x1F, osValid pulse, lmcReady=1:
  - B=16, exactly 2 beats; osReady=0 during beat0.
  - Beat0 bytes (low to high): 00,10,01,11,…,07,17; bits [511:128]=0.
  - Beat1 bytes: 08,18,…,0F,1F; then validToLMC=0.
- gen=2, N=1, symbols 0xBC,0x01..0x0F:
  - 16 beats with dataOut[7:0]=0xBC, 0x01, …, 0x0F; upper bits 0.
  - osReady rises in the same cycle as the last-beat handshake.
- gen=2, N=4, lmcReady=0 for 3 cycles at beat 5:
  - dataOut and validToLMC are stable for those 3 cycles.
  - Beats 6..15 resume in order; 16 handshakes total.
- Back-to-back, gen=2, N=2, osValid held high with two different ordered sets:
  - The second set is accepted on the first set's last beat.
  - Its beat0 follows with no idle cycle; 32 contiguous valid beats total.
- Saturation, gen=1, N=16:
  - W saturates to 512, B=64, T=256 → exactly 4 beats.
  - Beat0 byte m = lane (m mod 16), symbol (m div 16).
- N=3 and gen=0: osReady=0, validToLMC=0 for all cycles. Reset asserted during beat 2 of a gen=2, N=1 send: the next cycle shows validToLMC=0, dataOut=0, osReady=1.

Source files
------------

// File: rtl/os_encoder.sv
// Ordered-set transmit encoder: lane-major 16-symbol ordered set in,
// byte-interleaved PIPE-width beats out toward lane management.
module os_encoder #(
  parameter int GEN1_PIPEWIDTH = 64,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    gen,
  input  logic [4:0]    numberOfDetectedLanes,
  input  logic [2047:0] osIn,
  input  logic          osValid,
  output logic          osReady,
  input  logic          lmcReady,
  output logic [511:0]  dataOut,
  output logic          validToLMC
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [2047:0] os_q;
  logic [4:0]    n_q;
  logic [2:0]    s_q;
  logic [6:0]    b_q;
  logic [8:0]    t_q;
  logic [8:0]    byte_idx;

  logic          n_ok;
  logic          g_ok;
  logic          legal;
  logic [2:0]    s_in;
  int            pw;
  int            w;
  logic [6:0]    b_in;
  logic [8:0]    t_in;
  logic          last;
  logic          accept;

  always_comb begin
    n_ok = 1'b1;
    s_in = 3'd0;
    unique case (numberOfDetectedLanes)
      5'd1:    s_in = 3'd0;
      5'd2:    s_in = 3'd1;
      5'd4:    s_in = 3'd2;
      5'd8:    s_in = 3'd3;
      5'd16:   s_in = 3'd4;
      default: n_ok = 1'b0;
    endcase
  end

  always_comb begin
    g_ok = 1'b1;
    pw   = 0;
    unique case (gen)
      3'd1:    pw = GEN1_PIPEWIDTH;
      3'd2:    pw = GEN2_PIPEWIDTH;
      3'd3:    pw = GEN3_PIPEWIDTH;
      3'd4:    pw = GEN4_PIPEWIDTH;
      3'd5:    pw = GEN5_PIPEWIDTH;
      default: g_ok = 1'b0;
    endcase
  end

  // Beat width saturates at the 512-bit output bus.
  always_comb begin
    w = pw << s_in;
    if (w > 512)
      w = 512;
    b_in  = 7'(w >>> 3);
    t_in  = {numberOfDetectedLanes, 4'b0000};
    legal = n_ok && g_ok;
  end

  assign last = ({1'b0, byte_idx} + {3'b000, b_q})
              >= {1'b0, t_q};

  assign osReady = legal &&
    ((state == IDLE) || (last && lmcReady));
  assign accept     = osValid && osReady;
  assign validToLMC = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      os_q     <= '0;
      n_q      <= '0;
      s_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      state    <= SEND;
      os_q     <= osIn;
      n_q      <= numberOfDetectedLanes;
      s_q      <= s_in;
      b_q      <= b_in;
      t_q      <= t_in;
      byte_idx <= '0;
    end else if (state == SEND && lmcReady) begin
      if (last) begin
        state    <= IDLE;
        byte_idx <= '0;
      end else begin
        byte_idx <= byte_idx + {2'b00, b_q};
      end
    end
  end

  // Stream byte j = lane (j mod N), symbol (j div N).
  always_comb begin
    logic [8:0] idx;
    logic [3:0] lane;
    logic [3:0] sym;
    dataOut = '0;
    for (int m = 0; m < 64; m++) begin
      idx  = byte_idx + 9'(m);
      lane = 4'(idx & 9'(n_q - 5'd1));
      sym  = 4'(idx >> s_q);
      if (state == SEND && 7'(m) < b_q && idx < t_q)
        dataOut[8*m +: 8] = os_q[{lane, sym, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_os_encoder.sv
// Randomized and directed bench for os_encoder against a
// queue-of-expected-beats reference model.
module tb_os_encoder;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    gen;
  logic [4:0]    nl;
  logic [2047:0] os_in;
  logic          os_valid;
  logic          os_ready;
  logic          lmc_ready;
  logic [511:0]  data_out;
  logic          valid_lmc;

  int            n_chk = 0;
  int            n_fail = 0;
  int            acc = 0;
  logic [511:0]  q[$];

  always #5 clk = ~clk;

  os_encoder dut (
    .clk                   (clk),
    .reset                 (reset),
    .gen                   (gen),
    .numberOfDetectedLanes (nl),
    .osIn                  (os_in),
    .osValid               (os_valid),
    .osReady               (os_ready),
    .lmcReady              (lmc_ready),
    .dataOut               (data_out),
    .validToLMC            (valid_lmc)
  );

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] g,
                               input logic [4:0] n);
    return (g >= 1 && g <= 5) &&
      (n == 1 || n == 2 || n == 4 || n == 8 || n == 16);
  endfunction

  // Split one ordered set into its expected beats.
  task automatic push_os(input logic [2047:0] o,
                         input logic [2:0] g,
                         input logic [4:0] n);
    int pw;
    int w;
    int b;
    int t;
    int nn;
    logic [511:0] bt;
    nn = int'(n);
    pw = (g == 1) ? 64 : 8;
    w  = pw * nn;
    if (w > 512) w = 512;
    b = w / 8;
    t = 16 * nn;
    for (int s = 0; s < t; s += b) begin
      bt = '0;
      for (int m = 0; m < b; m++) begin
        if (s + m < t)
          bt[8*m +: 8] =
            o[128*((s+m) % nn) + 8*((s+m) / nn) +: 8];
      end
      q.push_back(bt);
    end
  endtask

  task automatic step(input logic [2:0] g,
                      input logic [4:0] n,
                      input logic [2047:0] o,
                      input bit v,
                      input bit lmc,
                      input bit rst);
    bit ev;
    bit er;
    logic [511:0] ed;
    @(negedge clk);
    gen = g; nl = n; os_in = o;
    os_valid = v; lmc_ready = lmc; reset = rst;
    #1;
    ev = (q.size() != 0);
    er = legal(g, n) &&
      (q.size() == 0 || (q.size() == 1 && lmc));
    ed = ev ? q[0] : '0;
    check("validToLMC", 512'(valid_lmc), 512'(ev));
    check("osReady", 512'(os_ready), 512'(er));
    check("dataOut", data_out, ed);
    if (rst) begin
      q.delete();
    end else begin
      if (ev && lmc) void'(q.pop_front());
      if (v && er) begin
        push_os(o, g, n);
        acc++;
      end
    end
  endtask

  function automatic logic [2047:0] pat(input int n,
                                        input bit bc);
    logic [2047:0] r;
    r = '0;
    for (int l = 0; l < n; l++)
      for (int k = 0; k < 16; k++)
        r[128*l + 8*k +: 8] = 8'(16*l + k);
    if (bc) r[7:0] = 8'hBC;
    return r;
  endfunction

  function automatic logic [2047:0] rnd_os();
    logic [2047:0] r;
    for (int i = 0; i < 64; i++)
      r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // mode 0: always ready, 1: stall cycles 6..8, 2: random
  task automatic run(input logic [2:0] g,
                     input logic [4:0] n,
                     input logic [2047:0] o0,
                     input logic [2047:0] o1,
                     input int nsets,
                     input int cyc,
                     input int mode);
    int a0;
    bit lmc;
    a0 = acc;
    for (int c = 0; c < cyc; c++) begin
      if (mode == 0) lmc = 1'b1;
      else if (mode == 1) lmc = !(c >= 6 && c <= 8);
      else lmc = ($urandom_range(0, 3) != 0);
      step(g, n, (acc == a0) ? o0 : o1,
           (acc - a0) < nsets, lmc, 1'b0);
    end
  endtask

  initial begin
    int nt[7];
    logic [2:0] g;
    logic [4:0] n;
    nt = '{1, 2, 4, 8, 16, 3, 0};
    reset = 1'b1; gen = 3'd0; nl = 5'd0;
    os_in = '0; os_valid = 1'b0; lmc_ready = 1'b0;
    repeat (2) @(negedge clk);

    run(3'd2, 5'd1, '0, '0, 0, 2, 0);
    run(3'd1, 5'd2, pat(2, 0), '0, 1, 5, 0);
    run(3'd2, 5'd1, pat(1, 1), '0, 1, 20, 0);
    run(3'd2, 5'd4, rnd_os(), '0, 1, 22, 1);
    run(3'd2, 5'd2, rnd_os(), rnd_os(), 2, 40, 0);
    run(3'd1, 5'd16, pat(16, 0), '0, 1, 8, 0);
    run(3'd2, 5'd3, rnd_os(), '0, 1, 6, 0);
    run(3'd0, 5'd4, rnd_os(), '0, 1, 6, 0);

    run(3'd2, 5'd1, pat(1, 1), '0, 1, 3, 0);
    step(3'd2, 5'd1, '0, 1'b0, 1'b1, 1'b1);
    run(3'd2, 5'd1, '0, '0, 0, 3, 0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 8) g = 3'($urandom_range(1, 5));
      else g = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd6;
      n = (c % 50 < 45) ? 5'(nt[$urandom_range(0, 4)])
                        : 5'(nt[$urandom_range(0, 6)]);
      step(g, n, rnd_os(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
